mem_arbiter: RTL and testbench

Shares the CPU's single memory port between instruction fetch (IF) and the load/store unit (LS). It sits between the core's fetch and memory stages and the unified instruction/data memory. It serialises requests with one transaction outstanding, routes read data back to the owning requester, and resolves simultaneous requests by a fixed or round-robin policy.

---
 rtl/mem_arbiter_if.sv | 44 ++++
 rtl/mem_arbiter.sv | 99 +++++++++
 tb/tb_mem_arbiter.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch, load/store and memory-side signals around mem_arbiter.
// slave is the arbiter's view; master is the core/memory side that drives it.
interface mem_arbiter_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic            if_req;
   logic [AW-1:0]   if_addr;
   logic            if_gnt;
   logic            if_rvalid;
   logic [DW-1:0]   if_rdata;

   logic            ls_req;
   logic            ls_we;
   logic [DW/8-1:0] ls_be;
   logic [AW-1:0]   ls_addr;
   logic [DW-1:0]   ls_wdata;
   logic            ls_gnt;
   logic            ls_rvalid;
   logic [DW-1:0]   ls_rdata;

   logic            mem_req;
   logic            mem_we;
   logic [DW/8-1:0] mem_be;
   logic [AW-1:0]   mem_addr;
   logic [DW-1:0]   mem_wdata;
   logic            mem_ready;
   logic            mem_rvalid;
   logic [DW-1:0]   mem_rdata;

   modport slave (
      input  if_req, if_addr, ls_req, ls_we, ls_be, ls_addr, ls_wdata,
             mem_ready, mem_rvalid, mem_rdata,
      output if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
             mem_req, mem_we, mem_be, mem_addr, mem_wdata
   );

   modport master (
      output if_req, if_addr, ls_req, ls_we, ls_be, ls_addr, ls_wdata,
             mem_ready, mem_rvalid, mem_rdata,
      input  if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
             mem_req, mem_we, mem_be, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one memory port between fetch (IF) and load/store (LS), one transaction in flight.
// Define ARB_ROUND_ROBIN_EN for round-robin tie breaking; otherwise LS wins ties.
module mem_arbiter #(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input logic          clk,
   input logic          reset,
   mem_arbiter_if.slave bus
);
   localparam int BW = DW / 8;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CMD  = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   localparam logic OWN_IF = 1'b0;
   localparam logic OWN_LS = 1'b1;

   typedef struct packed {
      logic          we;
      logic [BW-1:0] be;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
   } cmd_t;

   logic [1:0] state;
   logic       owner;
   logic       last;
   logic       win;
   logic       hs;
   logic       rsp;
   cmd_t       cmd;

   always_comb begin
      win = bus.ls_req ? OWN_LS : OWN_IF;
`ifdef ARB_ROUND_ROBIN_EN
      if (bus.if_req && bus.ls_req)
         win = (last == OWN_IF) ? OWN_LS : OWN_IF;
`endif
   end

`ifndef ARB_ROUND_ROBIN_EN
   // history is still tracked so both builds carry identical state
   logic unused_last;
   assign unused_last = last;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         owner <= OWN_IF;
         last  <= OWN_LS;
         cmd   <= '0;
      end else begin
         case (state)
            IDLE: if (bus.if_req || bus.ls_req) begin
               owner <= win;
               state <= CMD;
               if (win == OWN_LS) begin
                  cmd.we    <= bus.ls_we;
                  cmd.be    <= bus.ls_be;
                  cmd.addr  <= bus.ls_addr;
                  cmd.wdata <= bus.ls_wdata;
               end else begin
                  cmd.we    <= 1'b0;
                  cmd.be    <= {BW{1'b1}};
                  cmd.addr  <= bus.if_addr;
                  cmd.wdata <= '0;
               end
            end
            CMD: if (bus.mem_ready) begin
               last  <= owner;
               state <= cmd.we ? IDLE : RESP;
            end
            RESP: if (bus.mem_rvalid) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.mem_req   = (state == CMD);
   assign bus.mem_we    = cmd.we;
   assign bus.mem_be    = cmd.be;
   assign bus.mem_addr  = cmd.addr;
   assign bus.mem_wdata = cmd.wdata;

   assign hs  = bus.mem_req & bus.mem_ready;
   assign rsp = (state == RESP) & bus.mem_rvalid;

   assign bus.if_gnt    = hs & (owner == OWN_IF);
   assign bus.ls_gnt    = hs & (owner == OWN_LS);
   assign bus.if_rvalid = rsp & (owner == OWN_IF);
   assign bus.ls_rvalid = rsp & (owner == OWN_LS);

   // read data is gated so idle/non-owner ports never show stale bus values
   assign bus.if_rdata = bus.if_rvalid ? bus.mem_rdata : '0;
   assign bus.ls_rdata = bus.ls_rvalid ? bus.mem_rdata : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed plan items then random traffic, checked against a
// transaction-level model (pending requests per port, previous winner, timeline per txn).
module tb_mem_arbiter;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam bit W_IF = 1'b0;
   localparam bit W_LS = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
   localparam bit [2:0] TIE_ORDER = 3'b010;  // bit k = winner of tie k: IF, LS, IF
`else
   localparam bit [2:0] TIE_ORDER = 3'b111;  // LS, LS, LS
`endif

   logic clk = 1'b0;
   logic rst_n;
   int   tests = 0;
   int   fails = 0;

   mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();
   mem_arbiter #(.AW(AW), .DW(DW)) dut (.clk(clk), .reset(rst_n), .bus(bus));

   always #5 clk = ~clk;

   bit            if_pend, ls_pend, last_w, sticky;
   logic [AW-1:0] if_a, ls_a;
   logic          ls_we_m;
   logic [3:0]    ls_be_m;
   logic [DW-1:0] ls_wd;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_if_gnt"},    bus.if_gnt, 0);
      chk({tag, "_if_rvalid"}, bus.if_rvalid, 0);
      chk({tag, "_if_rdata"},  bus.if_rdata, 0);
      chk({tag, "_ls_gnt"},    bus.ls_gnt, 0);
      chk({tag, "_ls_rvalid"}, bus.ls_rvalid, 0);
      chk({tag, "_ls_rdata"},  bus.ls_rdata, 0);
      chk({tag, "_mem_req"},   bus.mem_req, 0);
      chk({tag, "_mem_we"},    bus.mem_we, 0);
      chk({tag, "_mem_be"},    bus.mem_be, 0);
      chk({tag, "_mem_addr"},  bus.mem_addr, 0);
      chk({tag, "_mem_wdata"}, bus.mem_wdata, 0);
   endtask

   task automatic drive_reqs();
      bus.if_req   = if_pend;
      bus.if_addr  = if_pend ? if_a : $urandom;
      bus.ls_req   = ls_pend;
      bus.ls_we    = ls_we_m;
      bus.ls_be    = ls_be_m;
      bus.ls_addr  = ls_a;
      bus.ls_wdata = ls_wd;
   endtask

   // one idle cycle with spurious ready/rvalid that must be ignored
   task automatic idle_chk(input string tag);
      drive_reqs();
      bus.mem_ready  = 1'b1;
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = $urandom;
      #1;
      chk({tag, "_mem_req"},   bus.mem_req, 0);
      chk({tag, "_if_rvalid"}, bus.if_rvalid, 0);
      chk({tag, "_ls_rvalid"}, bus.ls_rvalid, 0);
      @(negedge clk);
   endtask

   // Runs one transaction from an IDLE cycle; d = ready wait cycles, r = rvalid wait cycles.
   task automatic txn(input int d, input int r, input logic [DW-1:0] rd, output bit obs_w);
      bit            w, rdop;
      logic [AW-1:0] ea;
      logic [3:0]    eb;
      obs_w = W_IF;
      if (if_pend && ls_pend) begin
`ifdef ARB_ROUND_ROBIN_EN
         w = (last_w == W_IF) ? W_LS : W_IF;
`else
         w = W_LS;
`endif
      end else begin
         w = ls_pend;
      end
      rdop = (w == W_IF) || !ls_we_m;
      ea   = w ? ls_a : if_a;
      eb   = w ? ls_be_m : 4'hF;

      drive_reqs();
      bus.mem_ready  = 1'($urandom_range(0, 1));
      bus.mem_rvalid = 1'($urandom_range(0, 1));
      bus.mem_rdata  = $urandom;
      #1;
      chk("idle_mem_req",   bus.mem_req, 0);
      chk("idle_if_gnt",    bus.if_gnt, 0);
      chk("idle_ls_gnt",    bus.ls_gnt, 0);
      chk("idle_if_rvalid", bus.if_rvalid, 0);
      chk("idle_ls_rvalid", bus.ls_rvalid, 0);
      @(negedge clk);

      for (int i = 0; i <= d; i++) begin
         bus.mem_ready  = (i == d);
         bus.mem_rvalid = 1'($urandom_range(0, 1));
         if (i > 0) begin
            if (w) begin
               bus.ls_addr  = $urandom;
               bus.ls_wdata = $urandom;
            end else begin
               bus.if_addr = $urandom;
            end
         end
         #1;
         chk("cmd_mem_req",  bus.mem_req, 1);
         chk("cmd_mem_we",   bus.mem_we, w ? ls_we_m : 1'b0);
         chk("cmd_mem_be",   bus.mem_be, eb);
         chk("cmd_mem_addr", bus.mem_addr, ea);
         if (w) chk("cmd_mem_wdata", bus.mem_wdata, ls_wd);
         chk("cmd_if_gnt",    bus.if_gnt, (w == W_IF) && (i == d));
         chk("cmd_ls_gnt",    bus.ls_gnt, (w == W_LS) && (i == d));
         chk("cmd_if_rvalid", bus.if_rvalid, 0);
         chk("cmd_ls_rvalid", bus.ls_rvalid, 0);
         chk("cmd_other_rdata", w ? bus.if_rdata : bus.ls_rdata, 0);
         if (bus.ls_gnt) obs_w = W_LS;
         @(negedge clk);
      end

      last_w = w;
      if (!sticky) begin
         if (w) ls_pend = 1'b0;
         else   if_pend = 1'b0;
      end
      drive_reqs();

      if (rdop) begin
         for (int j = 0; j <= r; j++) begin
            bus.mem_ready  = 1'($urandom_range(0, 1));
            bus.mem_rvalid = (j == r);
            bus.mem_rdata  = (j == r) ? rd : $urandom;
            #1;
            chk("rsp_mem_req",   bus.mem_req, 0);
            chk("rsp_if_gnt",    bus.if_gnt, 0);
            chk("rsp_ls_gnt",    bus.ls_gnt, 0);
            chk("rsp_if_rvalid", bus.if_rvalid, (w == W_IF) && (j == r));
            chk("rsp_ls_rvalid", bus.ls_rvalid, (w == W_LS) && (j == r));
            if (j == r) chk("rsp_rdata", w ? bus.ls_rdata : bus.if_rdata, rd);
            chk("rsp_other_rdata", w ? bus.if_rdata : bus.ls_rdata, 0);
            @(negedge clk);
         end
      end
   endtask

   initial begin
      bit       w;
      bit [2:0] tie_exp;
      tie_exp = TIE_ORDER;
      sticky  = 1'b0;
      last_w  = W_LS;

      // reset with every input busy
      rst_n = 1'b0;
      if_pend = 1'b1; if_a = 32'h1234; ls_pend = 1'b1; ls_we_m = 1'b1;
      ls_be_m = 4'hF; ls_a = 32'h5678; ls_wd = 32'hFFFF_FFFF;
      drive_reqs();
      bus.mem_ready = 1'b1; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hA5A5_A5A5;
      repeat (2) @(negedge clk);
      #1 chk_all_zero("rst");
      if_pend = 1'b0; ls_pend = 1'b0;
      drive_reqs();
      @(negedge clk);
      rst_n = 1'b1;

      // single zero-wait fetch
      if_pend = 1'b1; if_a = 32'h100;
      txn(0, 0, 32'h0000_0013, w);
      chk("fetch_owner", w, W_IF);

      // store held off by three not-ready cycles
      ls_pend = 1'b1; ls_we_m = 1'b1; ls_be_m = 4'hF; ls_a = 32'h200; ls_wd = 32'hDEAD_BEEF;
      txn(3, 0, 32'h0, w);
      chk("store_owner", w, W_LS);
      idle_chk("store_done");

      // simultaneous requests held across three transactions
      sticky  = 1'b1;
      if_pend = 1'b1; if_a = 32'h400;
      ls_pend = 1'b1; ls_we_m = 1'b0; ls_be_m = 4'hF; ls_a = 32'h300; ls_wd = 32'h0;
      for (int k = 0; k < 3; k++) begin
         txn(0, 0, $urandom, w);
         chk($sformatf("tie_order%0d", k), w, tie_exp[k]);
      end
      sticky = 1'b0; if_pend = 1'b0; ls_pend = 1'b0;

      // spurious rvalid in IDLE, then a load with a slow response
      idle_chk("spurious");
      ls_pend = 1'b1; ls_we_m = 1'b0; ls_be_m = 4'h3; ls_a = 32'h600; ls_wd = 32'h1111_2222;
      txn(0, 5, 32'hCAFE_F00D, w);
      idle_chk("load_once");

      // reset while a fetch waits for its data
      if_pend = 1'b1; if_a = 32'h500;
      drive_reqs();
      bus.mem_ready = 1'b0; bus.mem_rvalid = 1'b0;
      @(negedge clk);
      bus.mem_ready = 1'b1;
      #1 chk("rstmid_gnt", bus.if_gnt, 1);
      @(negedge clk);
      if_pend = 1'b0; drive_reqs();
      bus.mem_ready = 1'b0; bus.mem_rvalid = 1'b0;
      #1 chk("rstmid_resp_req", bus.mem_req, 0);
      rst_n = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h7777_7777;
      #1 chk_all_zero("rstmid");
      @(negedge clk);
      #1 chk_all_zero("rstmid_hold");
      bus.mem_rvalid = 1'b0;
      rst_n = 1'b1;
      last_w = W_LS;
      @(negedge clk);
      idle_chk("rstmid_after");
      if_pend = 1'b1; if_a = 32'h104;
      txn(0, 0, 32'h0000_0093, w);
      chk("rstmid_fetch_owner", w, W_IF);

      // random traffic
      for (int k = 0; k < 40; k++) begin
         if (!if_pend && $urandom_range(0, 1) == 1) begin
            if_pend = 1'b1; if_a = $urandom;
         end
         if (!ls_pend && $urandom_range(0, 1) == 1) begin
            ls_pend = 1'b1; ls_we_m = 1'($urandom_range(0, 1)); ls_be_m = 4'($urandom);
            ls_a = $urandom; ls_wd = $urandom;
         end
         if (!if_pend && !ls_pend) begin
            if_pend = 1'b1; if_a = $urandom;
         end
         txn($urandom_range(0, 3), $urandom_range(0, 3), $urandom, w);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
